// File: rtl/halt_ctrl_pkg.sv
// Shared types for the halt/exit controller: cause codes, FSM states,
// and the halt-event priority picker.
package halt_ctrl_pkg;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_EBREAK  = 2'd1,
    HC_TOHOST  = 2'd2,
    HC_TIMEOUT = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        hit;
    cause_e      cause;
    logic [31:0] code;
  } halt_evt_t;

  // ebreak wins over tohost, tohost over the watchdog
  function automatic halt_evt_t pick_event(
    input logic        eb,
    input logic [31:0] a0,
    input logic        th,
    input logic [31:0] wd,
    input logic        to
  );
    halt_evt_t e;
    e = '{hit: 1'b0, cause: HC_NONE, code: 32'd0};
    if (eb)
      e = '{hit: 1'b1, cause: HC_EBREAK, code: a0};
    else if (th)
      e = '{hit: 1'b1, cause: HC_TOHOST,
            code: {1'b0, wd[31:1]}};
    else if (to)
      e = '{hit: 1'b1, cause: HC_TIMEOUT,
            code: TIMEOUT_CODE};
    return e;
  endfunction

endpackage

// File: rtl/halt_ctrl_if.sv
// MMIO store port and console byte stream of the halt controller.
// master = core/host side, slave = halt_ctrl side.
interface halt_ctrl_if;

  logic        mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ready;

  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output mmio_we,
    output mmio_addr,
    output mmio_wdata,
    input  mmio_ready,
    input  con_valid,
    input  con_data,
    output con_ready
  );

  modport slave (
    input  mmio_we,
    input  mmio_addr,
    input  mmio_wdata,
    output mmio_ready,
    output con_valid,
    output con_data,
    input  con_ready
  );

endinterface

// File: rtl/halt_ctrl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a register-file head.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Bench halt/exit device: ebreak/tohost/watchdog halt, cycle count, console FIFO.
// Define HALT_WATCHDOG_EN to enable the run-cycle watchdog (cause 3).
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'h1000_0000,
  parameter logic [31:0] CONSOLE_ADDR   = 32'h1000_0004,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd5_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ebreak_pulse,
  input  logic [31:0] a0,
  halt_ctrl_if.slave  bus,
  output logic        core_stall,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] exit_code,
  output logic [63:0] cycles
);

  state_e    st;
  cause_e    cause;
  halt_evt_t evt;

  logic run;
  logic con_hit;
  logic th_hit;
  logic to_hit;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic [7:0] fifo_head;

  assign run     = (st == ST_RUN);
  assign con_hit = (bus.mmio_addr == CONSOLE_ADDR);
  assign th_hit  = bus.mmio_we &&
                   (bus.mmio_addr == TOHOST_ADDR) &&
                   bus.mmio_wdata[0];

`ifdef HALT_WATCHDOG_EN
  assign to_hit = run &&
                  (cycles == TIMEOUT_CYCLES - 64'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  assign evt = pick_event(ebreak_pulse, a0, th_hit,
                          bus.mmio_wdata, to_hit);

  // full FIFO back-pressures console stores; no bypass
  assign bus.mmio_ready = !(run && con_hit && fifo_full);

  assign push = run && bus.mmio_we && con_hit &&
                !fifo_full;
  assign pop  = !fifo_empty && bus.con_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.mmio_wdata[7:0]),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign bus.con_valid = !fifo_empty;
  assign bus.con_data  = fifo_head;
  assign halt_cause    = cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_RUN;
      cycles     <= 64'd0;
      cause      <= HC_NONE;
      exit_code  <= 32'd0;
      core_stall <= 1'b0;
      halted     <= 1'b0;
    end else begin
      unique case (st)
        ST_RUN: begin
          cycles <= cycles + 64'd1;
          if (evt.hit) begin
            st         <= ST_DRAIN;
            cause      <= evt.cause;
            exit_code  <= evt.code;
            core_stall <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            st     <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          st <= ST_HALTED;
        end
        default: begin
          st <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: directed scenarios plus random
// episodes against a queue-based behavioural model.
module tb_halt_ctrl;

  localparam int          DEPTH = 8;
  localparam logic [31:0] TH    = 32'h1000_0000;
  localparam logic [31:0] CON   = 32'h1000_0004;
  localparam longint unsigned TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        ebreak_pulse;
  logic [31:0] a0;
  logic        core_stall;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] exit_code;
  logic [63:0] cycles;

  halt_ctrl_if bus ();

  halt_ctrl #(
    .TOHOST_ADDR    (TH),
    .CONSOLE_ADDR   (CON),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (64'd50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ebreak_pulse (ebreak_pulse),
    .a0           (a0),
    .bus          (bus),
    .core_stall   (core_stall),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .exit_code    (exit_code),
    .cycles       (cycles)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  longint unsigned m_cycles;
  byte unsigned    m_q[$];
  bit              m_drain;
  bit              m_halt;
  logic [1:0]      m_cause;
  logic [31:0]     m_code;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0;
    m_q.delete();
    m_drain = 0;
    m_halt  = 0;
    m_cause = 0;
    m_code  = 0;
  endtask

  function automatic bit m_ready();
    if (m_drain || m_halt) return 1'b1;
    if (bus.mmio_addr == CON && m_q.size() == DEPTH)
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outs();
    chk("cycles", cycles, m_cycles);
    chk("halt_cause", {62'd0, halt_cause}, {62'd0, m_cause});
    chk("exit_code", {32'd0, exit_code}, {32'd0, m_code});
    chk("halted", {63'd0, halted}, {63'd0, m_halt});
    chk("core_stall", {63'd0, core_stall},
        {63'd0, (m_drain || m_halt)});
    chk("con_valid", {63'd0, bus.con_valid},
        {63'd0, (m_q.size() != 0)});
    if (m_q.size() != 0)
      chk("con_data", {56'd0, bus.con_data}, {56'd0, m_q[0]});
  endtask

  task automatic idle();
    ebreak_pulse   = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.mmio_addr  = 32'd0;
    bus.mmio_wdata = 32'd0;
    bus.con_ready  = 1'b0;
  endtask

  task automatic store(input logic [31:0] ad,
                       input logic [31:0] wd);
    bus.mmio_we    = 1'b1;
    bus.mmio_addr  = ad;
    bus.mmio_wdata = wd;
  endtask

  // one clock: check ready, advance model, check registered outputs
  task automatic cyc();
    bit run, pop, push;
    byte unsigned d;
    #1;
    chk("mmio_ready", {63'd0, bus.mmio_ready}, {63'd0, m_ready()});
    run  = !m_drain && !m_halt;
    pop  = (m_q.size() > 0) && bus.con_ready;
    push = run && bus.mmio_we && bus.mmio_addr == CON &&
           m_q.size() < DEPTH;
    d    = bus.mmio_wdata[7:0];
    if (m_drain && m_q.size() == 0) begin
      m_drain = 0;
      m_halt  = 1;
    end else if (run) begin
      if (ebreak_pulse) begin
        m_drain = 1; m_cause = 1; m_code = a0;
      end else if (bus.mmio_we && bus.mmio_addr == TH &&
                   bus.mmio_wdata[0]) begin
        m_drain = 1; m_cause = 2;
        m_code = bus.mmio_wdata >> 1;
      end
`ifdef HALT_WATCHDOG_EN
      else if (m_cycles == TO - 1) begin
        m_drain = 1; m_cause = 3; m_code = 32'hFFFF_FFFF;
      end
`endif
      m_cycles++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_cycles", cycles, 64'd0);
    chk("rst_cause", {62'd0, halt_cause}, 64'd0);
    chk("rst_code", {32'd0, exit_code}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_stall", {63'd0, core_stall}, 64'd0);
    chk("rst_con_valid", {63'd0, bus.con_valid}, 64'd0);
    chk("rst_con_data", {56'd0, bus.con_data}, 64'd0);
    chk("rst_ready", {63'd0, bus.mmio_ready}, 64'd1);
    rst = 1'b0;
  endtask

  initial begin
    a0 = 32'd0;
    do_reset();

    // ebreak at run cycle 100, empty FIFO
    a0 = 32'h2A;
    repeat (100) cyc();
    ebreak_pulse = 1'b1;
    cyc();
    ebreak_pulse = 1'b0;
    chk("eb_not_yet", {63'd0, halted}, 64'd0);
    cyc();
    chk("eb_halted", {63'd0, halted}, 64'd1);
    chk("eb_cause", {62'd0, halt_cause}, 64'd1);
    chk("eb_code", {32'd0, exit_code}, 64'h2A);
    chk("eb_cycles", cycles, 64'd101);
    repeat (3) cyc();
    chk("eb_frozen", cycles, 64'd101);

    // tohost: bit0 clear ignored, bit0 set halts
    do_reset();
    store(TH, 32'h6);
    cyc();
    idle();
    repeat (3) cyc();
    chk("th6_no_halt", {63'd0, core_stall}, 64'd0);
    store(TH, 32'h7);
    cyc();
    idle();
    cyc();
    chk("th7_cause", {62'd0, halt_cause}, 64'd2);
    chk("th7_code", {32'd0, exit_code}, 64'd3);
    chk("th7_halted", {63'd0, halted}, 64'd1);

    // console bytes held back, then drained
    do_reset();
    store(CON, 32'h48);
    cyc();
    store(CON, 32'h69);
    cyc();
    idle();
    ebreak_pulse = 1'b1;
    cyc();
    ebreak_pulse = 1'b0;
    repeat (4) cyc();
    chk("con_stall", {63'd0, core_stall}, 64'd1);
    chk("con_drain", {63'd0, halted}, 64'd0);
    chk("con_H", {56'd0, bus.con_data}, 64'h48);
    bus.con_ready = 1'b1;
    cyc();
    chk("con_i", {56'd0, bus.con_data}, 64'h69);
    cyc();
    chk("con_empty", {63'd0, bus.con_valid}, 64'd0);
    chk("con_pre_halt", {63'd0, halted}, 64'd0);
    cyc();
    chk("con_halted", {63'd0, halted}, 64'd1);

    // full FIFO back-pressure
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      store(CON, 32'h30 + i);
      cyc();
    end
    store(CON, 32'h5A);
    #1;
    chk("full_ready0", {63'd0, bus.mmio_ready}, 64'd0);
    cyc();
    cyc();
    bus.con_ready = 1'b1;
    cyc();
    bus.con_ready = 1'b0;
    #1;
    chk("full_ready1", {63'd0, bus.mmio_ready}, 64'd1);
    cyc();
    idle();
    repeat (2) cyc();

    // ebreak beats tohost in the same cycle
    do_reset();
    a0 = 32'h55;
    repeat (5) cyc();
    store(TH, 32'h7);
    ebreak_pulse = 1'b1;
    cyc();
    idle();
    cyc();
    chk("prio_cause", {62'd0, halt_cause}, 64'd1);
    chk("prio_code", {32'd0, exit_code}, 64'h55);

    // watchdog, then async reset out of the final state
    do_reset();
    repeat (60) cyc();
`ifdef HALT_WATCHDOG_EN
    chk("wd_cause", {62'd0, halt_cause}, 64'd3);
    chk("wd_code", {32'd0, exit_code}, 64'hFFFF_FFFF);
    chk("wd_cycles", cycles, 64'd50);
    chk("wd_halted", {63'd0, halted}, 64'd1);
`else
    chk("nowd_cause", {62'd0, halt_cause}, 64'd0);
    chk("nowd_cycles", cycles, 64'd60);
    chk("nowd_halted", {63'd0, halted}, 64'd0);
`endif
    do_reset();

    // random episodes
    for (int ep = 0; ep < 20; ep++) begin
      int post;
      do_reset();
      post = 0;
      for (int c = 0; c < 200 && post < 6; c++) begin
        int sel;
        a0             = $urandom;
        ebreak_pulse   = ($urandom % 60) == 0;
        bus.mmio_we    = $urandom % 2;
        bus.con_ready  = $urandom % 2;
        bus.mmio_wdata = $urandom;
        sel = $urandom % 10;
        if (sel < 6) begin
          bus.mmio_addr = CON;
        end else if (sel == 6) begin
          bus.mmio_addr = TH;
          bus.mmio_wdata[0] = ($urandom % 8) == 0;
        end else begin
          bus.mmio_addr = $urandom;
        end
        cyc();
        if (halted) post++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
